// File: rtl/rtc_bcd_counter.sv
// ============================================================================
// Module   : rtc_bcd_counter
// Purpose  : 1 Hz prescaler plus a 24-hour BCD clock. A set mode allows
//            manual advance of hours and minutes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bcd_counter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PRESC_W = $clog2(CLK_HZ)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  output logic [3:0] hourdec_now,
  output logic [3:0] hourone_now,
  output logic [3:0] mindec_now,
  output logic [3:0] minone_now,
  output logic [3:0] secdec_now,
  output logic [3:0] secone_now,
  output logic       tick_sec,
  output logic       min_roll
);

  localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] r_presc;
  logic               r_inc_hour_q;
  logic               r_inc_min_q;
  logic [3:0]         r_hourdec, r_hourone, r_mindec, r_minone, r_secdec, r_secone;
  logic               r_tick;
  logic               r_min_roll;

  logic               w_hour_edge;
  logic               w_min_edge;
  logic               w_sec_done;
  logic [3:0]         w_hourdec, w_hourone, w_mindec, w_minone, w_secdec, w_secone;
  logic               w_min_roll;

  // Minute increment without carry-out: 59 wraps to 00.
  function automatic logic [7:0] min_inc(input logic [3:0] tens, input logic [3:0] units);
    if (units == 4'd9) begin
      min_inc = (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
    end else begin
      min_inc = {tens, units + 4'd1};
    end
  endfunction

  // Hour increment, 23 wraps to 00 (tens = 2 and units = 3).
  function automatic logic [7:0] hour_inc(input logic [3:0] tens, input logic [3:0] units);
    if ((tens == 4'd2) && (units == 4'd3)) begin
      hour_inc = 8'h00;
    end else if (units == 4'd9) begin
      hour_inc = {tens + 4'd1, 4'd0};
    end else begin
      hour_inc = {tens, units + 4'd1};
    end
  endfunction

  assign w_hour_edge = set_mode & inc_hour & ~r_inc_hour_q;
  assign w_min_edge  = set_mode & inc_min  & ~r_inc_min_q;
  // Set mode dominates a coincident terminal count.
  assign w_sec_done  = ~set_mode & (r_presc == C_PRESC_LAST);

  always_comb begin
    w_hourdec  = r_hourdec;
    w_hourone  = r_hourone;
    w_mindec   = r_mindec;
    w_minone   = r_minone;
    w_secdec   = r_secdec;
    w_secone   = r_secone;
    w_min_roll = 1'b0;
    if (set_mode) begin
      w_secdec = 4'd0;
      w_secone = 4'd0;
      if (w_min_edge) begin
        {w_mindec, w_minone} = min_inc(r_mindec, r_minone);
        w_min_roll           = 1'b1;
      end
      if (w_hour_edge) begin
        {w_hourdec, w_hourone} = hour_inc(r_hourdec, r_hourone);
      end
    end else if (w_sec_done) begin
      if (r_secone != 4'd9) begin
        w_secone = r_secone + 4'd1;
      end else begin
        w_secone = 4'd0;
        if (r_secdec != 4'd5) begin
          w_secdec = r_secdec + 4'd1;
        end else begin
          w_secdec             = 4'd0;
          w_min_roll           = 1'b1;
          {w_mindec, w_minone} = min_inc(r_mindec, r_minone);
          if ((r_mindec == 4'd5) && (r_minone == 4'd9)) begin
            {w_hourdec, w_hourone} = hour_inc(r_hourdec, r_hourone);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_inc_hour_q <= 1'b0;
      r_inc_min_q  <= 1'b0;
      r_hourdec    <= 4'd0;
      r_hourone    <= 4'd0;
      r_mindec     <= 4'd0;
      r_minone     <= 4'd0;
      r_secdec     <= 4'd0;
      r_secone     <= 4'd0;
      r_tick       <= 1'b0;
      r_min_roll   <= 1'b0;
    end else begin
      r_presc      <= (set_mode || w_sec_done) ? '0 : r_presc + 1'b1;
      r_inc_hour_q <= inc_hour;
      r_inc_min_q  <= inc_min;
      r_hourdec    <= w_hourdec;
      r_hourone    <= w_hourone;
      r_mindec     <= w_mindec;
      r_minone     <= w_minone;
      r_secdec     <= w_secdec;
      r_secone     <= w_secone;
      r_tick       <= w_sec_done;
      r_min_roll   <= w_min_roll;
    end
  end

  assign hourdec_now = r_hourdec;
  assign hourone_now = r_hourone;
  assign mindec_now  = r_mindec;
  assign minone_now  = r_minone;
  assign secdec_now  = r_secdec;
  assign secone_now  = r_secone;
  assign tick_sec    = r_tick;
  assign min_roll    = r_min_roll;

endmodule

`default_nettype wire

// File: doc/rtc_bcd_counter.md
# rtc_bcd_counter

Time-of-day keeper for the alarm clock. It divides the system clock down to a 1 Hz tick and maintains 24-hour BCD time as hours, minutes and seconds. A set mode lets the user advance hours and minutes with button edges. It drives the `*_now` digit buses and the 1 Hz tick consumed by the alarm comparison/sound stage downstream.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: input clock frequency; one second = `CLK_HZ` cycles; legal range ≥2.
- `PRESC_W`, default `$clog2(CLK_HZ)`: prescaler width.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `set_mode` in 1: high = time frozen, manual setting enabled.
- `inc_hour` in 1: level from synchronized button; each rising edge in set mode advances hours.
- `inc_min` in 1: level from synchronized button; each rising edge in set mode advances minutes.
- `hourdec_now` out 4: hour tens digit, 0–2.
- `hourone_now` out 4: hour units digit, 0–9 (0–3 when tens = 2).
- `mindec_now` out 4: minute tens digit, 0–5.
- `minone_now` out 4: minute units digit, 0–9.
- `secdec_now` out 4: second tens digit, 0–5.
- `secone_now` out 4: second units digit, 0–9.
- `tick_sec` out 1: one-`clk` pulse per elapsed second; used as the downstream second strobe.
- `min_roll` out 1: one-`clk` pulse when minutes change by counting or by `inc_min`.

## Operation
- Reset values: all digits 0 (00:00:00); `tick_sec` = 0; `min_roll` = 0; prescaler = 0; button edge registers = 0.
- The block has two modes, selected directly by `set_mode` level. It has no other FSM.
- RUN mode (`set_mode` = 0):
  - Prescaler counts 0..`CLK_HZ`-1 and wraps to 0.
  - On the cycle the prescaler equals `CLK_HZ`-1, `tick_sec` pulses and seconds advance by one.
- Carry chain on each second:
  - `secone` 9→0 carries into `secdec`.
  - `secdec` 5→0 carries into `minone`, and `min_roll` pulses.
  - `minone` 9→0 carries into `mindec`.
  - `mindec` 5→0 carries into hours.
  - Hours count 00..23; 23:59:59 → 00:00:00.
- SET mode (`set_mode` = 1):
  - Prescaler is held at 0.
  - `tick_sec` stays 0.
  - Seconds digits are forced to 00 on every cycle.
- Button edges:
  - Edge detect is `inc_x & ~inc_x_q`. The `_q` register samples every cycle in both modes.
  - An edge seen in RUN mode is discarded.
- `inc_min` edge in SET mode:
  - Minutes advance 00..59 and wrap 59→00 with no carry into hours.
  - `min_roll` pulses.
- `inc_hour` edge in SET mode: hours advance 00..23 and wrap 23→00.
- Simultaneous `inc_hour` and `inc_min` edges: both apply in the same cycle, independently.
- BCD rules:
  - Each digit is a separate 4-bit register.
  - No binary-to-BCD conversion.
  - Hour wrap is detected as tens = 2 and units = 3.
  - Digits never take values outside the ranges listed in Interface.
- Leaving SET mode (1→0): the prescaler restarts from 0, so the first `tick_sec` arrives exactly `CLK_HZ` cycles after the first RUN cycle.

## Timing
- All outputs are registered.
- Digits change on the same rising edge that `tick_sec` goes high. Both are visible one cycle after the prescaler terminal count is sampled.
- In RUN mode with `set_mode` held low, `tick_sec` period is exactly `CLK_HZ` cycles, high for 1 cycle.
- Set-mode increment latency: the button rising edge is sampled at edge N; the digit updates at edge N+1.
  - Exactly one increment per rising edge.
  - A held button produces nothing further.
- `set_mode` rising at the same edge as the prescaler terminal count: SET wins; no tick and no increment.
- Asynchronous `rst` mid-count clears everything immediately. After release, the first tick arrives `CLK_HZ` cycles later.

## Test plan
Use `CLK_HZ` = 4 for all scenarios.
- **Reset:** assert `rst` mid-count → all digits 0 immediately, `tick_sec` = 0; after release, `tick_sec` pulses on cycle 4, then every 4 cycles.
- **Full rollover:** set time to 23:59, run 60 ticks → at the 60th tick time reads 00:00:00, `min_roll` pulses on that tick, no illegal digit at any point.
- **Minute carry:** from 09:59:59 one tick → 10:00:00; from 19:59:59 → 20:00:00.
- **Set minutes:**
  - Enter SET at 12:34:27 → seconds read 00 next cycle.
  - 26 `inc_min` edges → 12:00, hours unchanged.
  - Holding `inc_min` high for 10 cycles → single increment.
- **Set hours plus simultaneous edges:**
  - 5 `inc_hour` edges from 21:xx → 02:xx.
  - Simultaneous edges at 23:59 → 00:00.
  - Edges pulsed in RUN mode → no change.
- **Exit SET:** drop `set_mode` → no `tick_sec` for 3 cycles, first pulse on cycle 4, time 00:00:01 after it.
